// File: rtl/rom_arbiter_pkg.sv
// Shared types and ROM contents for the ROM arbiter: FSM states, grant owner
// encoding and the four constant ROM words.
package rom_arbiter_pkg;

    localparam int NBITS_ADDR_DEF = 2;
    localparam int NBITS_DATA_DEF = 4;
    localparam int SCAN_DIV_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_MAN,
        RD_SCAN
    } state_t;

    typedef enum logic {
        OWN_MAN  = 1'b0,
        OWN_SCAN = 1'b1
    } owner_t;

    localparam logic [3:0] DADO_00 = 4'b0011;
    localparam logic [3:0] DADO_01 = 4'b0110;
    localparam logic [3:0] DADO_10 = 4'b1001;
    localparam logic [3:0] DADO_11 = 4'b1100;

endpackage

// File: rtl/rom_4x4.sv
// Combinational constant ROM; addresses past the four defined words read zero.
module rom_4x4
    import rom_arbiter_pkg::*;
#(
    parameter int NBITS_ADDR = NBITS_ADDR_DEF,
    parameter int NBITS_DATA = NBITS_DATA_DEF
) (
    input  logic [NBITS_ADDR-1:0] addr,
    output logic [NBITS_DATA-1:0] data
);

    always_comb begin
        data = '0;
        case (addr)
            NBITS_ADDR'(0): data = NBITS_DATA'(DADO_00);
            NBITS_ADDR'(1): data = NBITS_DATA'(DADO_01);
            NBITS_ADDR'(2): data = NBITS_DATA'(DADO_10);
            NBITS_ADDR'(3): data = NBITS_DATA'(DADO_11);
            default:        data = '0;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the constant ROM between a manual port and a periodic auto-scan
// engine; each read is a grant cycle plus a read cycle, round-robin on ties.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int NBITS_ADDR = NBITS_ADDR_DEF,
    parameter int NBITS_DATA = NBITS_DATA_DEF,
    parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  man_req,
    input  logic [NBITS_ADDR-1:0] man_addr,
    output logic                  man_ack,
    output logic [NBITS_DATA-1:0] man_data,
    input  logic                  scan_en,
    output logic [NBITS_ADDR-1:0] scan_addr,
    output logic [NBITS_DATA-1:0] scan_data,
    output logic                  scan_valid,
    output logic                  busy,
    output logic                  grant_owner
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t                  state, state_nxt;
    owner_t                  owner, owner_nxt;
    logic [NBITS_ADDR-1:0]   rd_addr, rd_addr_nxt;
    logic [TW-1:0]           tick_cnt;
    logic                    scan_pend;
    logic                    tick;
    logic [NBITS_DATA-1:0]   rom_data;

    rom_4x4 #(
        .NBITS_ADDR (NBITS_ADDR),
        .NBITS_DATA (NBITS_DATA)
    ) u_rom (
        .addr (rd_addr),
        .data (rom_data)
    );

    assign tick        = scan_en && (tick_cnt == TW'(SCAN_DIV - 1));
    assign busy        = (state != IDLE);
    assign grant_owner = owner;

    // Manual wins unless scan is pending and manual owned the last grant.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rd_addr_nxt = rd_addr;
        case (state)
            IDLE: begin
                if (man_req && (!scan_pend || owner == OWN_SCAN)) begin
                    state_nxt   = RD_MAN;
                    owner_nxt   = OWN_MAN;
                    rd_addr_nxt = man_addr;
                end else if (scan_pend) begin
                    state_nxt   = RD_SCAN;
                    owner_nxt   = OWN_SCAN;
                    rd_addr_nxt = scan_addr;
                end
            end
            RD_MAN:  state_nxt = IDLE;
            RD_SCAN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_SCAN;
            rd_addr    <= '0;
            man_ack    <= 1'b0;
            man_data   <= '0;
            scan_data  <= '0;
            scan_valid <= 1'b0;
            scan_addr  <= '0;
            tick_cnt   <= '0;
            scan_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            rd_addr    <= rd_addr_nxt;
            man_ack    <= (state == RD_MAN);
            scan_valid <= (state == RD_SCAN);
            if (state == RD_MAN)
                man_data <= rom_data;
            if (state == RD_SCAN)
                scan_data <= rom_data;
            // Pointer advances after the pulse so scan_addr matches scan_data.
            if (scan_valid)
                scan_addr <= scan_addr + 1'b1;
            if (!scan_en) begin
                tick_cnt  <= '0;
                scan_pend <= 1'b0;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                // Completion clears the request; a coincident tick is dropped.
                if (state == RD_SCAN)
                    scan_pend <= 1'b0;
                else if (tick)
                    scan_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench: directed stimulus queues expected pulses, a negedge
// monitor pops and compares whenever an ack/valid pulse appears.
module tb_rom_arbiter;

    typedef struct {
        logic [3:0] data;
        logic [1:0] addr;
        int         gap;
    } exp_t;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    always #5 clk_2 = ~clk_2;

    logic       m4_req, m4_ack, s4_en, s4_valid, b4, o4;
    logic [1:0] m4_addr, s4_addr;
    logic [3:0] m4_data, s4_data;
    logic       m1_req, m1_ack, s1_en, s1_valid, b1, o1;
    logic [1:0] m1_addr, s1_addr;
    logic [3:0] m1_data, s1_data;

    rom_arbiter #(.NBITS_ADDR(2), .NBITS_DATA(4), .SCAN_DIV(4)) u4 (
        .clk_2(clk_2), .reset(reset), .man_req(m4_req), .man_addr(m4_addr),
        .man_ack(m4_ack), .man_data(m4_data), .scan_en(s4_en),
        .scan_addr(s4_addr), .scan_data(s4_data), .scan_valid(s4_valid),
        .busy(b4), .grant_owner(o4)
    );

    rom_arbiter #(.NBITS_ADDR(2), .NBITS_DATA(4), .SCAN_DIV(1)) u1 (
        .clk_2(clk_2), .reset(reset), .man_req(m1_req), .man_addr(m1_addr),
        .man_ack(m1_ack), .man_data(m1_data), .scan_en(s1_en),
        .scan_addr(s1_addr), .scan_data(s1_data), .scan_valid(s1_valid),
        .busy(b1), .grant_owner(o1)
    );

    exp_t q_m4[$], q_s4[$], q_m1[$], q_s1[$];
    int checks = 0, errors = 0, cyc = 0;
    int last_m4 = 0, last_s4 = 0, last_m1 = 0, last_s1 = 0;

    always @(posedge clk_2) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pulse(input string name, input exp_t e, input logic [3:0] d,
                         input logic [1:0] a, input bit use_a, input int last);
        chk({name, "_data"}, 32'(d), 32'(e.data));
        if (use_a)
            chk({name, "_addr"}, 32'(a), 32'(e.addr));
        if (e.gap != 0)
            chk({name, "_gap"}, cyc - last, e.gap);
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s_unexpected: pulse at cycle %0d, none expected", name, cyc);
    endtask

    always @(negedge clk_2) begin
        exp_t e;
        if (m4_ack === 1'b1) begin
            if (q_m4.size() == 0) unexpected("m4");
            else begin e = q_m4.pop_front(); pulse("m4", e, m4_data, 2'd0, 1'b0, last_m4); end
            last_m4 = cyc;
        end
        if (s4_valid === 1'b1) begin
            if (q_s4.size() == 0) unexpected("s4");
            else begin e = q_s4.pop_front(); pulse("s4", e, s4_data, s4_addr, 1'b1, last_s4); end
            last_s4 = cyc;
        end
        if (m1_ack === 1'b1) begin
            if (q_m1.size() == 0) unexpected("m1");
            else begin e = q_m1.pop_front(); pulse("m1", e, m1_data, 2'd0, 1'b0, last_m1); end
            last_m1 = cyc;
        end
        if (s1_valid === 1'b1) begin
            if (q_s1.size() == 0) unexpected("s1");
            else begin e = q_s1.pop_front(); pulse("s1", e, s1_data, s1_addr, 1'b1, last_s1); end
            last_s1 = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    initial begin
        m4_req = 0; m4_addr = 0; s4_en = 0;
        m1_req = 0; m1_addr = 0; s1_en = 0;
        reset = 1;
        step(2);
        chk("rst_busy", 32'(b4), 0);
        chk("rst_ack", 32'(m4_ack), 0);
        chk("rst_man_data", 32'(m4_data), 0);
        chk("rst_scan_valid", 32'(s4_valid), 0);
        chk("rst_scan_data", 32'(s4_data), 0);
        chk("rst_scan_addr", 32'(s4_addr), 0);
        chk("rst_owner4", 32'(o4), 1);
        chk("rst_owner1", 32'(o1), 1);

        // single manual read, addr 2
        reset = 0;
        step(1);
        m4_req = 1; m4_addr = 2;
        q_m4.push_back('{4'b1001, 2'd0, 0});
        step(1); m4_req = 0;
        chk("man_busy_t1", 32'(b4), 1);
        chk("man_ack_t1", 32'(m4_ack), 0);
        step(1);
        chk("man_ack_t2", 32'(m4_ack), 1);
        chk("man_data_t2", 32'(m4_data), 'b1001);
        chk("man_busy_t2", 32'(b4), 0);
        chk("man_owner", 32'(o4), 0);
        step(1);
        chk("man_ack_t3", 32'(m4_ack), 0);

        // reset during RD_MAN
        m4_req = 1; m4_addr = 1;
        step(1);
        chk("midrst_busy_before", 32'(b4), 1);
        reset = 1; m4_req = 0;
        step(1);
        chk("midrst_busy", 32'(b4), 0);
        chk("midrst_ack", 32'(m4_ack), 0);
        chk("midrst_man_data", 32'(m4_data), 0);
        chk("midrst_owner", 32'(o4), 1);

        // scan wrap with SCAN_DIV=4; this cycle is cycle 0
        reset = 0; s4_en = 1;
        q_s4.push_back('{4'b0011, 2'd0, 0});
        q_s4.push_back('{4'b0110, 2'd1, 4});
        q_s4.push_back('{4'b1001, 2'd2, 4});
        q_s4.push_back('{4'b1100, 2'd3, 4});
        q_s4.push_back('{4'b0011, 2'd0, 4});
        q_s4.push_back('{4'b0110, 2'd1, 4});
        step(5);
        chk("scan_c5_valid", 32'(s4_valid), 0);
        chk("scan_c5_busy", 32'(b4), 1);
        step(1);
        chk("scan_c6_valid", 32'(s4_valid), 1);
        chk("scan_c6_data", 32'(s4_data), 'b0011);
        step(18);
        chk("scan_c24_busy", 32'(b4), 0);
        step(1);
        chk("dis_rdscan_busy", 32'(b4), 1);
        s4_en = 0;
        step(1);
        chk("dis_valid", 32'(s4_valid), 1);
        chk("dis_addr", 32'(s4_addr), 1);
        step(1);
        chk("dis_addr_inc", 32'(s4_addr), 2);
        chk("dis_tick0", 32'(u4.tick_cnt), 0);
        step(10);
        chk("dis_addr_hold", 32'(s4_addr), 2);
        chk("dis_idle", 32'(b4), 0);
        chk("dis_tick_hold", 32'(u4.tick_cnt), 0);

        // tie-breaking and tick overflow with SCAN_DIV=1
        reset = 1;
        step(1);
        reset = 0; m1_req = 1; m1_addr = 3; s1_en = 1;
        for (int i = 0; i < 6; i++)
            q_m1.push_back('{4'b1100, 2'd0, (i == 0) ? 0 : 4});
        q_s1.push_back('{4'b0011, 2'd0, 0});
        q_s1.push_back('{4'b0110, 2'd1, 4});
        q_s1.push_back('{4'b1001, 2'd2, 4});
        q_s1.push_back('{4'b1100, 2'd3, 4});
        q_s1.push_back('{4'b0011, 2'd0, 4});
        step(2);
        chk("tie_c2_ack", 32'(m1_ack), 1);
        chk("tie_c2_data", 32'(m1_data), 'b1100);
        chk("tie_c2_owner", 32'(o1), 0);
        step(1);
        chk("tie_c3_owner", 32'(o1), 1);
        chk("tie_c3_busy", 32'(b1), 1);
        step(1);
        chk("tie_c4_valid", 32'(s1_valid), 1);
        chk("tie_c4_data", 32'(s1_data), 'b0011);
        step(17);
        m1_req = 0; s1_en = 0;
        step(1);
        chk("tie_c22_ack", 32'(m1_ack), 1);
        step(8);
        chk("tie_end_idle", 32'(b1), 0);

        chk("q_m4_empty", q_m4.size(), 0);
        chk("q_s4_empty", q_s4.size(), 0);
        chk("q_m1_empty", q_m1.size(), 0);
        chk("q_s1_empty", q_s1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Sequencer and arbiter that shares the 4-entry x 4-bit constant ROM between two requesters: a manual port driven from the switches and an internal auto-scan engine that walks the ROM addresses periodically. Each read is a 2-cycle transaction through a 3-state FSM, with round-robin arbitration on ties. The block sits between the board inputs (SWI) and the LED/LCD debug outputs in `top`, and exports busy and owner status for the LCD.

## Interface
- `NBITS_ADDR`, 2: ROM address width; ROM depth is 2**NBITS_ADDR.
- `NBITS_DATA`, 4: ROM word width.
- `SCAN_DIV`, 4: clk_2 cycles between auto-scan requests; must be at least 1.

- `clk_2`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `man_req`  in  1: manual read request; level-sensitive.
- `man_addr`  in  NBITS_ADDR: manual read address; sampled at grant.
- `man_ack`  out  1: one-cycle pulse; `man_data` is valid in that cycle.
- `man_data`  out  NBITS_DATA: last manual read result; held between reads.
- `scan_en`  in  1: enables the auto-scan engine.
- `scan_addr`  out  NBITS_ADDR: current scan pointer.
- `scan_data`  out  NBITS_DATA: last scan read result; held between reads.
- `scan_valid`  out  1: one-cycle pulse; `scan_data` is valid in that cycle.
- `busy`  out  1: high while the FSM is not in IDLE.
- `grant_owner`  out  1: owner of the most recent grant; 0 = manual, 1 = scan.

## Operation
- **ROM contents:** addr 0 = 4'b0011, 1 = 4'b0110, 2 = 4'b1001, 3 = 4'b1100.
- **FSM states:** IDLE, RD_MAN, RD_SCAN.
- **IDLE transitions:**
  - Only `man_req` pending: latch `man_addr` into `rd_addr`, go to RD_MAN.
  - Only `scan_pend` set: latch `scan_addr` into `rd_addr`, go to RD_SCAN.
  - Both pending: grant the requester that is not `grant_owner`, then update `grant_owner`.
- **RD_MAN:** at the edge, register ROM[`rd_addr`] into `man_data`, set `man_ack` = 1, return to IDLE.
- **RD_SCAN:** at the edge, register ROM[`rd_addr`] into `scan_data`, set `scan_valid` = 1, clear `scan_pend`, return to IDLE.
- **Ack/valid pulses:** `man_ack` and `scan_valid` are registered and high for exactly one cycle.
- **Manual request handling:** `man_req` still high in the IDLE cycle that carries the ack starts a new transaction. Holding `man_req` therefore gives one read every 2 cycles, alternating with scan when both are pending.
- **Scan tick counter:**
  - `tick_cnt` counts 0..SCAN_DIV-1 while `scan_en` = 1.
  - When it wraps it sets `scan_pend`.
  - A tick that arrives while `scan_pend` is already set is dropped; ticks do not accumulate.
- **Scan pointer:** `scan_addr` increments (modulo 4, 3 wraps to 0) on the edge that ends the `scan_valid` cycle. During `scan_valid`, `scan_addr` is the address of `scan_data`.
- **scan_en low:**
  - `tick_cnt` is forced to 0 and `scan_pend` is cleared.
  - An RD_SCAN already in flight completes normally.
  - `scan_addr` holds its value.
- **busy:** `busy` = (state != IDLE).

## Timing
- **Reset values** (on any edge with `reset` = 1):
  - state IDLE, `man_ack` 0, `man_data` 0, `scan_data` 0, `scan_valid` 0.
  - `scan_addr` 0, `tick_cnt` 0, `scan_pend` 0, `busy` 0, `grant_owner` 1 (so manual wins the first tie).
- **Manual latency:** `man_req` high in IDLE at cycle t gives `busy` = 1 at t+1 and `man_ack` plus data at t+2.
- **Scan latency:** `scan_pend` set in cycle t (IDLE, no manual request) gives `scan_valid` at t+2.
- **First scan after reset:** with `scan_en` = 1 from the first cycle after reset and SCAN_DIV = 4, `scan_pend` rises in cycle 4 and `scan_valid` with data 0011 occurs in cycle 6.
- **Reset mid-transaction:** state returns to IDLE at that edge. No ack or valid is produced for the aborted read, and the manual requester must re-request.
- **Simultaneous tick and scan grant:** the new tick is dropped because `scan_pend` is still set in that cycle.

## Structure
- **Package `rom_arbiter_pkg`:**
  - `state_t` enum {IDLE, RD_MAN, RD_SCAN}.
  - `owner_t` enum {OWN_MAN = 0, OWN_SCAN = 1}.
  - ROM word constants DADO_00, DADO_01, DADO_10, DADO_11.
  - Default widths.
- **Sub-module `rom_4x4`:** purely combinational address-to-data lookup using the package constants.
- **`rom_arbiter` itself:** FSM, arbiter, tick counter, scan pointer and output registers.

## Test plan
- **Reset mid-transaction:** assert `reset` during RD_MAN → next cycle all outputs at reset values, no `man_ack`, `grant_owner` = 1.
- **Single manual read:** `scan_en` = 0, `man_req` pulsed 1 cycle with `man_addr` = 2 → `man_ack` exactly 2 cycles later with `man_data` = 4'b1001; `busy` high for 1 cycle.
- **Scan wrap:** `scan_en` = 1, SCAN_DIV = 4, no manual requests → `scan_valid` pulses with data 0011, 0110, 1001, 1100, 0011. Each pulse is 4 cycles apart with `scan_addr` = 0, 1, 2, 3, 0.
- **Tie-breaking:** hold `man_req` = 1 (`man_addr` = 3) with `scan_en` = 1 and SCAN_DIV = 1 → grants alternate manual, scan, manual, scan. Manual first, `man_data` = 1100, one ack or valid every 2 cycles.
- **Scan disable mid-read:** drop `scan_en` in the RD_SCAN cycle → `scan_valid` still asserts once, `scan_addr` increments once, then no further scan reads and `tick_cnt` = 0.
- **Tick overflow:** SCAN_DIV = 1 while manual holds the port for 6 reads → at most one pending scan read is serviced and no extra `scan_valid` pulses appear.
